// File: rtl/pulse_dec_pkg.sv
// Shared types and constants for the pulse train decoder.
package pulse_dec_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    HOLD
  } pulse_dec_state_t;

endpackage

// File: rtl/pulse_train_decoder_fsm.sv
// State sequencing for the pulse train decoder; emits one-cycle load strobes
// that the top uses to update its counters and result registers.
module pulse_train_decoder_fsm
  import pulse_dec_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             sin,
  input  logic             rising,
  input  logic             timeout_hit,
  input  logic             ack,
  output pulse_dec_state_t state,
  output logic             start,
  output logic             high_tick,
  output logic             fall,
  output logic             rehigh,
  output logic             low_tick,
  output logic             hold_load,
  output logic             release_hold
);

  pulse_dec_state_t state_q;
  pulse_dec_state_t state_d;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (rising) state_d = HIGH;
      HIGH: begin
        if (tick && !sin) state_d = timeout_hit ? HOLD : LOW;
      end
      LOW: begin
        if (tick && sin)             state_d = HIGH;
        else if (tick && timeout_hit) state_d = HOLD;
      end
      HOLD: if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load strobes decoded from the current state and inputs.
  always_comb begin
    start        = (state_q == IDLE) && rising;
    high_tick    = (state_q == HIGH) && tick && sin;
    fall         = (state_q == HIGH) && tick && !sin;
    rehigh       = (state_q == LOW) && tick && sin;
    low_tick     = (state_q == LOW) && tick && !sin;
    hold_load    = (fall || low_tick) && timeout_hit;
    release_hold = (state_q == HOLD) && ack;
  end

  assign state = state_q;

endmodule

// File: rtl/pulse_train_decoder.sv
// Pulse train decoder: counts pulses and measures the first pulse's high width
// in clk_en ticks, reporting the result after an idle gap via valid/ack.
module pulse_train_decoder
  import pulse_dec_pkg::*;
#(
  parameter int unsigned PULSE_NUM_BITS   = 16,
  parameter int unsigned PULSE_WIDTH_BITS = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clk_en,
  input  logic                        in,
  input  logic [PULSE_WIDTH_BITS:0]   idle_timeout,
  input  logic                        ack,
  output logic [PULSE_NUM_BITS-1:0]   pulse_num,
  output logic [PULSE_WIDTH_BITS-1:0] pulse_width,
  output logic                        irregular,
  output logic                        overflow,
  output logic                        valid,
  output logic                        busy
);

  localparam int unsigned NB = PULSE_NUM_BITS;
  localparam int unsigned WB = PULSE_WIDTH_BITS;
  localparam int unsigned LB = PULSE_WIDTH_BITS + 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sin_prev_q, sin_prev_d;
  logic [WB-1:0]          high_cnt_q, high_cnt_d;
  logic [WB-1:0]          ref_width_q, ref_width_d;
  logic [NB-1:0]          num_cnt_q, num_cnt_d;
  logic [LB-1:0]          low_cnt_q, low_cnt_d;
  logic                   irr_q, irr_d;
  logic                   ovf_q, ovf_d;
  logic [NB-1:0]          pulse_num_q, pulse_num_d;
  logic [WB-1:0]          pulse_width_q, pulse_width_d;
  logic                   irregular_q, irregular_d;
  logic                   overflow_q, overflow_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;

  logic                   sin;
  logic                   rising;
  logic                   timeout_hit;
  logic [WB-1:0]          high_inc;
  logic [NB-1:0]          num_inc;
  logic [LB-1:0]          low_inc;

  pulse_dec_state_t       state;
  logic                   start, high_tick, fall, rehigh, low_tick, hold_load, release_hold;

  assign sin    = sync_q[SYNC_STAGES-1];
  assign rising = clk_en && sin && !sin_prev_q;

  // Saturating increments shared by the counter update logic.
  always_comb begin
    high_inc = (high_cnt_q == '1) ? high_cnt_q : high_cnt_q + WB'(1);
    num_inc  = (num_cnt_q == '1) ? num_cnt_q : num_cnt_q + NB'(1);
    low_inc  = (low_cnt_q == '1) ? low_cnt_q : low_cnt_q + LB'(1);
  end

  // A falling tick is low tick 1, so HIGH compares against 1 rather than low_inc.
  always_comb begin
    timeout_hit = (state == HIGH) ? (idle_timeout == LB'(1)) : (low_inc == idle_timeout);
  end

  pulse_train_decoder_fsm u_fsm (
    .clk          (clk),
    .reset        (reset),
    .tick         (clk_en),
    .sin          (sin),
    .rising       (rising),
    .timeout_hit  (timeout_hit),
    .ack          (ack),
    .state        (state),
    .start        (start),
    .high_tick    (high_tick),
    .fall         (fall),
    .rehigh       (rehigh),
    .low_tick     (low_tick),
    .hold_load    (hold_load),
    .release_hold (release_hold)
  );

  // Synchronizer, edge history, counters and result capture.
  always_comb begin
    sync_d        = {sync_q[SYNC_STAGES-2:0], in};
    sin_prev_d    = clk_en ? sin : sin_prev_q;
    high_cnt_d    = high_cnt_q;
    ref_width_d   = ref_width_q;
    num_cnt_d     = num_cnt_q;
    low_cnt_d     = low_cnt_q;
    irr_d         = irr_q;
    ovf_d         = ovf_q;
    pulse_num_d   = pulse_num_q;
    pulse_width_d = pulse_width_q;
    irregular_d   = irregular_q;
    overflow_d    = overflow_q;

    if (start) begin
      high_cnt_d = WB'(1);
      num_cnt_d  = '0;
      irr_d      = 1'b0;
      ovf_d      = 1'b0;
    end
    if (high_tick) begin
      high_cnt_d = high_inc;
      if (high_inc == '1) ovf_d = 1'b1;
    end
    if (fall) begin
      num_cnt_d = num_inc;
      if (num_inc == '1) ovf_d = 1'b1;
      if (num_cnt_q == '0) begin
        ref_width_d = high_cnt_q;
      end else if (high_cnt_q != ref_width_q) begin
        irr_d = 1'b1;
      end
      low_cnt_d = LB'(1);
    end
    if (rehigh) high_cnt_d = WB'(1);
    if (low_tick) low_cnt_d = low_inc;

    // Capture uses the _d values so a flag raised on the final falling tick is kept.
    if (hold_load) begin
      pulse_num_d   = num_cnt_d;
      pulse_width_d = ref_width_d;
      irregular_d   = irr_d;
      overflow_d    = ovf_d;
    end

    valid_d = hold_load || (valid_q && !release_hold);
    busy_d  = start || (busy_q && !hold_load);
  end

  // All registers clear on asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q        <= '0;
      sin_prev_q    <= 1'b0;
      high_cnt_q    <= '0;
      ref_width_q   <= '0;
      num_cnt_q     <= '0;
      low_cnt_q     <= '0;
      irr_q         <= 1'b0;
      ovf_q         <= 1'b0;
      pulse_num_q   <= '0;
      pulse_width_q <= '0;
      irregular_q   <= 1'b0;
      overflow_q    <= 1'b0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      sin_prev_q    <= sin_prev_d;
      high_cnt_q    <= high_cnt_d;
      ref_width_q   <= ref_width_d;
      num_cnt_q     <= num_cnt_d;
      low_cnt_q     <= low_cnt_d;
      irr_q         <= irr_d;
      ovf_q         <= ovf_d;
      pulse_num_q   <= pulse_num_d;
      pulse_width_q <= pulse_width_d;
      irregular_q   <= irregular_d;
      overflow_q    <= overflow_d;
      valid_q       <= valid_d;
      busy_q        <= busy_d;
    end
  end

  assign pulse_num   = pulse_num_q;
  assign pulse_width = pulse_width_q;
  assign irregular   = irregular_q;
  assign overflow    = overflow_q;
  assign valid       = valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pulse_train_decoder.sv
// Self-checking bench for pulse_train_decoder using a result scoreboard.
module tb_pulse_train_decoder;

  localparam int NB = 16;
  localparam int WB = 8;
  localparam int WMAX = (1 << WB) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_en;
  logic          in_sig;
  logic [WB:0]   idle_timeout;
  logic          ack;
  logic [NB-1:0] pulse_num;
  logic [WB-1:0] pulse_width;
  logic          irregular;
  logic          overflow;
  logic          valid;
  logic          busy;

  typedef struct {
    int num;
    int width;
    bit irr;
    bit ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   en_period = 1;

  always #5 clk = ~clk;

  pulse_train_decoder #(
    .PULSE_NUM_BITS   (NB),
    .PULSE_WIDTH_BITS (WB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en       (clk_en),
    .in           (in_sig),
    .idle_timeout (idle_timeout),
    .ack          (ack),
    .pulse_num    (pulse_num),
    .pulse_width  (pulse_width),
    .irregular    (irregular),
    .overflow     (overflow),
    .valid        (valid),
    .busy         (busy)
  );

  // One time-base tick: clk_en is high only on the last clk of the period.
  task automatic do_tick();
    for (int i = 0; i < en_period; i++) begin
      clk_en = (i == en_period - 1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold_level(input bit v, input int n);
    in_sig = v;
    repeat (n) do_tick();
  endtask

  // Drives up to three pulses and pushes the result the decoder should report.
  task automatic send_train(input int n, input int w0, input int w1, input int w2, input int gap);
    int   w[3];
    int   s;
    exp_t e;
    w[0] = w0; w[1] = w1; w[2] = w2;
    e.num   = n;
    e.width = (w0 > WMAX) ? WMAX : w0;
    e.irr   = 1'b0;
    e.ovf   = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = (w[i] > WMAX) ? WMAX : w[i];
      if (s >= WMAX) e.ovf = 1'b1;
      if (s != e.width) e.irr = 1'b1;
      hold_level(1'b1, w[i]);
      if (i < n - 1) hold_level(1'b0, gap);
    end
    in_sig = 1'b0;
    sb.push_back(e);
  endtask

  task automatic wait_valid(output int ticks);
    ticks = 0;
    while (valid !== 1'b1 && ticks < 2000) begin
      do_tick();
      ticks++;
    end
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_valid: valid=%0b after %0d ticks, required 1", valid, ticks);
    end
  endtask

  task automatic check_front(input string tag);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: empty, required one entry", tag);
      return;
    end
    e = sb[0];
    checks += 6;
    if (valid !== 1'b1) begin errors++; $display("FAIL %s valid: got %0b need 1", tag, valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy: got %0b need 0", tag, busy); end
    if (pulse_num !== NB'(e.num)) begin errors++; $display("FAIL %s pulse_num: got %0d need %0d", tag, pulse_num, e.num); end
    if (pulse_width !== WB'(e.width)) begin errors++; $display("FAIL %s pulse_width: got %0d need %0d", tag, pulse_width, e.width); end
    if (irregular !== e.irr) begin errors++; $display("FAIL %s irregular: got %0b need %0b", tag, irregular, e.irr); end
    if (overflow !== e.ovf) begin errors++; $display("FAIL %s overflow: got %0b need %0b", tag, overflow, e.ovf); end
  endtask

  task automatic do_ack(input string tag);
    clk_en = (en_period == 1);
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL %s ack: valid=%0b need 0", tag, valid); end
    if (sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic check_latency(input string tag, input int got, input int need);
    checks++;
    if (got !== need) begin errors++; $display("FAIL %s latency: got %0d ticks need %0d", tag, got, need); end
  endtask

  task automatic check_cleared(input string tag);
    checks++;
    if ({pulse_num, pulse_width, irregular, overflow, valid, busy} !== '0) begin
      errors++;
      $display("FAIL %s outputs: num=%0d width=%0d irr=%0b ovf=%0b valid=%0b busy=%0b need all 0",
               tag, pulse_num, pulse_width, irregular, overflow, valid, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; clk_en = 1'b0; in_sig = 1'b0; ack = 1'b0; idle_timeout = '0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) do_tick();
  endtask

  // With continuous clk_en the synchronizer adds 2 ticks to the timeout.
  task automatic test_generator();
    int t;
    idle_timeout = 9'd10;
    send_train(3, 4, 4, 4, 4);
    wait_valid(t);
    check_latency("generator", t, 12);
    check_front("generator");
    do_ack("generator");
  endtask

  task automatic test_irregular();
    int t;
    idle_timeout = 9'd8;
    send_train(3, 4, 4, 5, 3);
    wait_valid(t);
    check_front("irregular");
    do_ack("irregular");
  endtask

  task automatic test_overflow();
    int t;
    idle_timeout = 9'd5;
    send_train(1, 300, 0, 0, 0);
    wait_valid(t);
    check_front("overflow");
    do_ack("overflow");
  endtask

  task automatic test_timeouts();
    int t;
    bit seen_valid, seen_idle;
    idle_timeout = 9'd1;
    send_train(1, 2, 0, 0, 0);
    wait_valid(t);
    check_latency("timeout1", t, 3);
    check_front("timeout1");
    do_ack("timeout1");

    idle_timeout = 9'd0;
    hold_level(1'b1, 3); hold_level(1'b0, 3); hold_level(1'b1, 3);
    seen_valid = 1'b0; seen_idle = 1'b0;
    in_sig = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      do_tick();
      if (valid !== 1'b0) seen_valid = 1'b1;
      if (busy !== 1'b1) seen_idle = 1'b1;
    end
    checks += 2;
    if (seen_valid) begin errors++; $display("FAIL no_timeout valid: got 1 need 0"); end
    if (seen_idle) begin errors++; $display("FAIL no_timeout busy: got 0 need 1"); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) do_tick();
  endtask

  task automatic test_handshake();
    int t;
    idle_timeout = 9'd6;
    send_train(2, 4, 4, 0, 3);
    wait_valid(t);
    check_front("hold_first");
    hold_level(1'b1, 3); hold_level(1'b0, 3);
    hold_level(1'b1, 3); hold_level(1'b0, 3);
    check_front("hold_ignore");
    hold_level(1'b1, 3);
    do_ack("hold_ack");
    hold_level(1'b1, 5);
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL stale_high busy: got %0b need 0", busy); end
    if (valid !== 1'b0) begin errors++; $display("FAIL stale_high valid: got %0b need 0", valid); end
    hold_level(1'b0, 3);
    send_train(1, 4, 0, 0, 0);
    wait_valid(t);
    check_front("fresh_pulse");
    do_ack("fresh_pulse");
  endtask

  task automatic test_reset_mid();
    int t;
    idle_timeout = 9'd6;
    hold_level(1'b1, 3); hold_level(1'b0, 3); hold_level(1'b1, 2);
    reset = 1'b0;
    #2;
    check_cleared("reset_mid");
    @(negedge clk);
    reset = 1'b1;
    hold_level(1'b0, 3);
    send_train(2, 3, 3, 0, 3);
    wait_valid(t);
    check_front("after_reset");
    do_ack("after_reset");
  endtask

  // With sparse ticks the synchronizer settles between ticks, so no extra latency.
  task automatic test_slow_en();
    int t;
    en_period = 4;
    idle_timeout = 9'd6;
    hold_level(1'b0, 2);
    send_train(2, 3, 3, 0, 3);
    wait_valid(t);
    check_latency("slow", t, 6);
    check_front("slow");
    do_ack("slow");
    idle_timeout = 9'd8;
    hold_level(1'b0, 2);
    send_train(3, 4, 4, 5, 3);
    wait_valid(t);
    check_front("slow_irregular");
    do_ack("slow_irregular");
    en_period = 1;
  endtask

  initial begin
    test_reset();
    test_generator();
    test_irregular();
    test_overflow();
    test_timeouts();
    test_handshake();
    test_reset_mid();
    test_slow_en();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard drain: %0d left, need 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_train_decoder.md
Name: pulse_train_decoder

Overview:
Receive-side counterpart of the step-pulse generator. It watches an incoming pulse train, counts its pulses and measures the high width of each pulse in clk_en ticks. The train ends after a programmable idle gap, and the block then reports the pulse count and width through a valid/ack handshake. It is used in closed-loop checks of the motor step path and to decode external step/dir inputs.

Parameters:
PULSE_NUM_BITS, 16, width of the pulse count field.
PULSE_WIDTH_BITS, 8, width of the measured pulse-width field.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
clk_en  input  1  time-base tick; all counting happens only on cycles with clk_en=1.
in  input  1  asynchronous pulse input.
idle_timeout  input  PULSE_WIDTH_BITS+1  number of consecutive low ticks that ends a train; 0 disables the timeout.
ack  input  1  consumer accepts the result.
pulse_num  output  PULSE_NUM_BITS  number of pulses in the finished train.
pulse_width  output  PULSE_WIDTH_BITS  high width of the first pulse, in ticks.
irregular  output  1  some later pulse width differed from the first pulse.
overflow  output  1  the count or a width saturated.
valid  output  1  result fields are stable.
busy  output  1  a train is in progress.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs and internal registers go to 0; the state goes to IDLE.
  - Mid-operation reset discards any partial train.
- Input conditioning:
  - in passes through a 2-flop synchronizer clocked every clk; call the result sin.
  - sin_prev updates only on ticks, including ticks in HOLD.
  - Requirement on the environment: clk_en is either continuous or has a period of at least 3 clk.
- Rising edge: a tick with sin=1 and sin_prev=0.
- FSM states: IDLE, HIGH, LOW, HOLD.
  - IDLE: on a rising edge, go to HIGH with high_cnt=1, num_cnt=0, irregular=0 and overflow=0 (internal).
  - HIGH, tick with sin=1: high_cnt+1, saturating at 2^PULSE_WIDTH_BITS-1; reaching saturation sets overflow.
  - HIGH, tick with sin=0 (falling tick, which also counts as low tick 1):
    - num_cnt+1, saturating; saturation sets overflow.
    - If this is the first pulse, ref_width=high_cnt.
    - Otherwise, if high_cnt differs from ref_width, set irregular.
    - low_cnt=1.
    - If idle_timeout==1, go to HOLD; otherwise go to LOW.
  - LOW, tick with sin=1: go to HIGH with high_cnt=1.
  - LOW, tick with sin=0: low_cnt+1.
    - When the new value equals idle_timeout, go to HOLD.
    - With idle_timeout=0, never leave LOW; only reset recovers.
    - low_cnt saturates and does not wrap.
  - Entering HOLD: register pulse_num=num_cnt, pulse_width=ref_width, irregular, overflow; set valid=1.
  - HOLD:
    - Input edges are ignored.
    - ack is sampled every clk, not gated by clk_en; ack=1 gives valid=0 and IDLE on the next edge.
    - The result fields hold their values until the next entry into HOLD.
    - ack while valid=0 is ignored.
- After HOLD, a pulse only counts after a fresh rising edge; an input already high at ack is not counted.
- busy=1 in HIGH and LOW, 0 in IDLE and HOLD.
- All outputs are registered.
- Latency: valid rises on the clk edge of the idle_timeout-th consecutive low tick, counting the falling tick as the first.

Decomposition:
- Shared package pulse_dec_pkg holds:
  - typedef enum pulse_dec_state_t {IDLE, HIGH, LOW, HOLD};
  - the constant SYNC_STAGES=2.
- One sub-module, pulse_train_decoder_fsm, holds the state register and next-state logic. Its inputs are tick, sin, rising, timeout_hit and ack; its outputs are the state and load strobes.
- Counters and result registers stay in the top module.

Test Plan:
1. Generator-style train: 3 pulses, 4 ticks high and 4 low each, idle_timeout=10, continuous clk_en -> pulse_num=3, pulse_width=4, irregular=0, overflow=0; valid rises 10 ticks after the last falling tick; busy=0.
2. Widths 4,4,5 with 3-tick gaps, idle_timeout=8 -> pulse_num=3, pulse_width=4, irregular=1.
3. One 300-tick high pulse with PULSE_WIDTH_BITS=8 -> pulse_width=255, overflow=1, pulse_num=1.
4. idle_timeout=1, one 2-tick pulse -> HOLD directly from the falling tick, pulse_num=1. Then idle_timeout=0 with 2 pulses and 1000 low ticks -> valid stays 0 and busy stays 1.
5. Handshake, with valid=1:
   - 2 extra pulses -> no change to outputs.
   - ack with in held high -> valid=0 next clk.
   - in stays high -> no count.
   - Next fresh pulse of 4 ticks -> new result pulse_num=1.
6. Reset=0 mid-HIGH of the second pulse -> all outputs 0 immediately, with no clk needed. Release reset and send 2 pulses of width 3 -> pulse_num=2, pulse_width=3. Also check clk_en every 4th clk gives the same counts in ticks.
